// File: rtl/sr_bank_ctrl.sv
// Round-robin sequencer for a bank of clocked SR flops: grants one of two requesters,
// pulses a single s or r bit, then verifies the flop's q feedback and reports completion.
module sr_bank_ctrl #(
    parameter int unsigned N_FLAGS = 8,
    parameter int unsigned IDX_W   = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [2*IDX_W-1:0]   req_idx,
    input  logic [1:0]           req_op,
    output logic [N_FLAGS-1:0]   sr_s,
    output logic [N_FLAGS-1:0]   sr_r,
    input  logic [N_FLAGS-1:0]   sr_q,
    output logic                 done,
    output logic                 err,
    output logic                 gnt_id
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StDrive = 2'd1;
    localparam logic [1:0] StCheck = 2'd2;

    logic [1:0]         state_q, state_d;
    logic               rr_q, rr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               op_q, op_d;
    logic               gid_q, gid_d;
    logic               rng_err_q, rng_err_d;
    logic [N_FLAGS-1:0] sr_s_q, sr_s_d;
    logic [N_FLAGS-1:0] sr_r_q, sr_r_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               gnt_id_q, gnt_id_d;

    logic               sel;
    logic [IDX_W-1:0]   acc_idx;
    logic               acc_op;
    logic               acc_in_range;
    logic               accept;
    logic [N_FLAGS-1:0] one_hot;
    logic [N_FLAGS-1:0] q_shift;

    // A lone requester always wins; on contention the round-robin pointer decides.
    always_comb begin
        if (req_valid == 2'b10) begin
            sel = 1'b1;
        end else if (req_valid == 2'b01) begin
            sel = 1'b0;
        end else begin
            sel = rr_q;
        end
        acc_idx      = sel ? req_idx[2*IDX_W-1:IDX_W] : req_idx[IDX_W-1:0];
        acc_op       = req_op[sel];
        acc_in_range = 32'(acc_idx) < N_FLAGS;
        one_hot      = {{(N_FLAGS-1){1'b0}}, 1'b1} << acc_idx;
        q_shift      = sr_q >> idx_q;
        if (rst_n && (state_q == StIdle) && (|req_valid)) begin
            req_ready = sel ? 2'b10 : 2'b01;
        end else begin
            req_ready = 2'b00;
        end
        accept = |(req_valid & req_ready);
    end

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        idx_d     = idx_q;
        op_d      = op_q;
        gid_d     = gid_q;
        rng_err_d = rng_err_q;
        sr_s_d    = '0;
        sr_r_d    = '0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        gnt_id_d  = gnt_id_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    rr_d  = ~sel;
                    idx_d = acc_idx;
                    op_d  = acc_op;
                    gid_d = sel;
                    if (acc_in_range) begin
                        // Pulse is registered here so it appears for exactly the DRIVE cycle.
                        state_d   = StDrive;
                        rng_err_d = 1'b0;
                        if (acc_op) begin
                            sr_s_d = one_hot;
                        end else begin
                            sr_r_d = one_hot;
                        end
                    end else begin
                        state_d   = StCheck;
                        rng_err_d = 1'b1;
                    end
                end
            end
            StDrive: begin
                state_d = StCheck;
            end
            StCheck: begin
                done_d   = 1'b1;
                err_d    = rng_err_q | (q_shift[0] != op_q);
                gnt_id_d = gid_q;
                state_d  = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            rr_q      <= 1'b0;
            idx_q     <= '0;
            op_q      <= 1'b0;
            gid_q     <= 1'b0;
            rng_err_q <= 1'b0;
            sr_s_q    <= '0;
            sr_r_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            gnt_id_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            idx_q     <= idx_d;
            op_q      <= op_d;
            gid_q     <= gid_d;
            rng_err_q <= rng_err_d;
            sr_s_q    <= sr_s_d;
            sr_r_q    <= sr_r_d;
            done_q    <= done_d;
            err_q     <= err_d;
            gnt_id_q  <= gnt_id_d;
        end
    end

    assign sr_s   = sr_s_q;
    assign sr_r   = sr_r_q;
    assign done   = done_q;
    assign err    = err_q;
    assign gnt_id = gnt_id_q;

endmodule

// File: tb/tb_sr_bank_ctrl.sv
// Bench for sr_bank_ctrl: directed commands against an SR bank model, with a scoreboard
// of expected {gnt_id, err} completions checked by an independent monitor.
module tb_sr_bank_ctrl;

    localparam int unsigned N_FLAGS = 8;
    localparam int unsigned IDX_W   = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [1:0]           req_valid;
    logic [1:0]           req_ready;
    logic [2*IDX_W-1:0]   req_idx;
    logic [1:0]           req_op;
    logic [N_FLAGS-1:0]   sr_s;
    logic [N_FLAGS-1:0]   sr_r;
    logic [N_FLAGS-1:0]   sr_q;
    logic                 done;
    logic                 err;
    logic                 gnt_id;

    logic [N_FLAGS-1:0]   bank_q = '0;
    logic                 force_q3 = 1'b0;

    int n_checks = 0;
    int n_fails  = 0;
    logic [1:0] exp_q[$];

    sr_bank_ctrl #(.N_FLAGS(N_FLAGS), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_idx   (req_idx),
        .req_op    (req_op),
        .sr_s      (sr_s),
        .sr_r      (sr_r),
        .sr_q      (sr_q),
        .done      (done),
        .err       (err),
        .gnt_id    (gnt_id)
    );

    always #5 clk = ~clk;

    // SR flop bank on the shared clock; q feedback can be forced low on bit 3.
    always @(posedge clk) bank_q <= (bank_q | sr_s) & ~sr_r;
    assign sr_q = force_q3 ? (bank_q & ~8'h08) : bank_q;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: completion scoreboard plus bus invariants, sampled on the falling edge.
    always @(negedge clk) begin
        logic [1:0] e;
        if (rst_n) begin
            check("s_and_r", 32'(sr_s & sr_r), 32'd0);
            check("onehot0", 32'($countones(sr_s | sr_r) <= 1), 32'd1);
        end
        if (done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("gnt_id", 32'(gnt_id), 32'(e[1]));
                check("err", 32'(err), 32'(e[0]));
            end
        end
    end

    task automatic wait_ready(input logic [1:0] exp_rdy);
        int k = 0;
        @(negedge clk);
        while (req_ready == 2'b00 && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("ready", 32'(req_ready), 32'(exp_rdy));
    endtask

    // Single-requester command: handshake, optional push of expected completion, then drain.
    task automatic cmd(input logic who, input logic [IDX_W-1:0] idx, input logic op,
                       input logic exp_err, input int drain);
        req_valid = who ? 2'b10 : 2'b01;
        req_op    = who ? 2'b10 : 2'b01;
        if (!op) req_op = 2'b00;
        req_idx   = who ? {idx, {IDX_W{1'b0}}} : {{IDX_W{1'b0}}, idx};
        wait_ready(who ? 2'b10 : 2'b01);
        exp_q.push_back({who, exp_err});
        @(posedge clk);
        #1 req_valid = 2'b00;
        repeat (drain) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 2'b01;
        req_idx   = 8'h01;
        req_op    = 2'b01;

        // Reset held for 3 cycles with A valid
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_ready", 32'(req_ready), 32'd0);
            check("rst_sr", 32'({sr_s, sr_r}), 32'd0);
            check("rst_done", 32'({done, err, gnt_id}), 32'd0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(req_ready), 32'd1);
        exp_q.push_back(2'b00);
        @(posedge clk);
        #1 req_valid = 2'b00;
        @(negedge clk);
        check("post_rst_s", 32'(sr_s), 32'h02);
        repeat (3) @(posedge clk);
        #1;

        // Single set of idx 5, then reset of idx 5
        req_valid = 2'b01; req_idx = 8'h05; req_op = 2'b01;
        wait_ready(2'b01);
        exp_q.push_back(2'b00);
        @(posedge clk);
        #1 req_valid = 2'b00;
        @(negedge clk);
        check("set5_c1_s", 32'(sr_s), 32'h20);
        check("set5_c1_r", 32'(sr_r), 32'h00);
        check("set5_c1_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("set5_c2_s", 32'(sr_s), 32'h00);
        check("set5_c2_q", 32'(sr_q[5]), 32'd1);
        @(negedge clk);
        check("set5_c3_done", 32'(done), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 2'b01; req_idx = 8'h05; req_op = 2'b00;
        wait_ready(2'b01);
        exp_q.push_back(2'b00);
        @(posedge clk);
        #1 req_valid = 2'b00;
        @(negedge clk);
        check("rst5_c1_r", 32'(sr_r), 32'h20);
        check("rst5_c1_s", 32'(sr_s), 32'h00);
        @(negedge clk);
        check("rst5_c2_q", 32'(sr_q[5]), 32'd0);
        repeat (2) @(posedge clk);
        #1;

        // Contention after a fresh reset: A set 2 vs B reset 2
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        req_valid = 2'b11; req_idx = {4'd2, 4'd2}; req_op = 2'b01;
        wait_ready(2'b01);
        exp_q.push_back(2'b00);
        @(posedge clk);
        #1 req_valid = 2'b10;
        @(negedge clk);
        check("cont_c1_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("cont_c2_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("cont_c3_ready", 32'(req_ready), 32'd2);
        exp_q.push_back(2'b10);
        @(posedge clk);
        #1 req_valid = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check("cont_final_q2", 32'(bank_q[2]), 32'd0);

        // Round-robin: both valid continuously for 6 commands
        req_valid = 2'b11; req_idx = {4'd1, 4'd0}; req_op = 2'b11;
        for (int i = 0; i < 6; i++) begin
            wait_ready((i % 2 == 0) ? 2'b01 : 2'b10);
            exp_q.push_back({1'((i % 2) != 0), 1'b0});
            @(posedge clk);
        end
        #1 req_valid = 2'b00;
        repeat (3) @(posedge clk);
        #1;

        // Range error: B reset idx 9
        req_valid = 2'b10; req_idx = {4'd9, 4'd0}; req_op = 2'b00;
        wait_ready(2'b10);
        exp_q.push_back(2'b11);
        @(posedge clk);
        #1 req_valid = 2'b00;
        @(negedge clk);
        check("range_c1_sr", 32'({sr_s, sr_r}), 32'd0);
        check("range_c1_done", 32'(done), 32'd0);
        @(negedge clk);
        check("range_c2_sr", 32'({sr_s, sr_r}), 32'd0);
        check("range_c2_done_err", 32'({done, err}), 32'd3);
        @(posedge clk);
        #1;

        // q mismatch: set idx 3 with feedback forced low
        force_q3 = 1'b1;
        cmd(1'b0, 4'd3, 1'b1, 1'b1, 3);
        force_q3 = 1'b0;
        // Already-set flop still pulses and completes cleanly
        cmd(1'b1, 4'd3, 1'b1, 1'b0, 3);

        // Abort: reset during DRIVE drops the command
        req_valid = 2'b01; req_idx = 8'h04; req_op = 2'b01;
        wait_ready(2'b01);
        @(posedge clk);
        #1 req_valid = 2'b00;
        @(negedge clk);
        check("abort_c1_s", 32'(sr_s), 32'h10);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_sr", 32'({sr_s, sr_r}), 32'd0);
        check("abort_outs", 32'({done, err, gnt_id, req_ready}), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
